// File: rtl/cdb_rr_arbiter.sv
// rtl/cdb_rr_arbiter.sv - Common Data Bus round-robin arbiter with registered broadcast stage
// Optional per-source grant / conflict performance counters under CDB_PERF_CNT_EN.
module cdb_rr_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int BW_TAG      = 1,
  parameter int BW_DATA     = 32,
  parameter int BW_SRC      = $clog2(NUM_SRC),
  parameter int BW_PERF_CNT = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0]             i_src_valid,
  output logic [NUM_SRC-1:0]             i_src_ready,
  input  logic [NUM_SRC*BW_TAG-1:0]      i_src_tag,
  input  logic [NUM_SRC*BW_DATA-1:0]     i_src_data,
  input  logic                           i_flush,
  output logic                           o_cdb_valid,
  output logic [BW_TAG-1:0]              o_cdb_tag,
  output logic [BW_DATA-1:0]             o_cdb_data,
  output logic [BW_SRC-1:0]              o_cdb_src,
  output logic [NUM_SRC*BW_PERF_CNT-1:0] o_perf_grant_cnt,
  output logic [BW_PERF_CNT-1:0]         o_perf_conflict_cnt
);

  localparam int SW = BW_SRC + 1;

  logic [BW_SRC-1:0]  ptr;
  logic [BW_SRC-1:0]  win;
  logic [BW_SRC-1:0]  idx;
  logic [SW-1:0]      sum;
  logic               any_valid;
  logic               grant;
  logic [BW_TAG-1:0]  tag_arr  [NUM_SRC];
  logic [BW_DATA-1:0] data_arr [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign tag_arr[g]  = i_src_tag[g*BW_TAG +: BW_TAG];
    assign data_arr[g] = i_src_data[g*BW_DATA +: BW_DATA];
  end

  // Scan from ptr upward, wrapping; the first valid source wins.
  always_comb begin
    win       = '0;
    idx       = '0;
    sum       = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(NUM_SRC)) sum = sum - SW'(NUM_SRC);
      idx = sum[BW_SRC-1:0];
      if (!any_valid && i_src_valid[idx]) begin
        any_valid = 1'b1;
        win       = idx;
      end
    end
  end

  // Ready is only raised at a valid winner, so grant implies transfer.
  assign grant = rst_n & ~i_flush & any_valid;

  always_comb begin
    i_src_ready = '0;
    if (grant) i_src_ready[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_cdb_valid <= 1'b0;
      o_cdb_tag   <= '0;
      o_cdb_data  <= '0;
      o_cdb_src   <= '0;
      ptr         <= '0;
    end else begin
      o_cdb_valid <= grant;
      if (grant) begin
        o_cdb_tag  <= tag_arr[win];
        o_cdb_data <= data_arr[win];
        o_cdb_src  <= win;
        ptr        <= (win == BW_SRC'(NUM_SRC - 1)) ? '0 : win + BW_SRC'(1);
      end
    end
  end

`ifdef CDB_PERF_CNT_EN
  logic                   multi;
  logic                   seen;
  logic [BW_PERF_CNT-1:0] grant_cnt [NUM_SRC];
  logic [BW_PERF_CNT-1:0] conflict_cnt;

  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_src_valid[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
  end

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SRC; k++) grant_cnt[k] <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (grant && win == BW_SRC'(k) && grant_cnt[k] != '1)
          grant_cnt[k] <= grant_cnt[k] + BW_PERF_CNT'(1);
      end
      if (multi && !i_flush && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + BW_PERF_CNT'(1);
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_perf_pack
    assign o_perf_grant_cnt[g*BW_PERF_CNT +: BW_PERF_CNT] = grant_cnt[g];
  end
  assign o_perf_conflict_cnt = conflict_cnt;
`else
  assign o_perf_grant_cnt    = '0;
  assign o_perf_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// tb/tb_cdb_rr_arbiter.sv - directed self-checking bench for cdb_rr_arbiter
module tb_cdb_rr_arbiter;

  localparam int NS = 4;
  localparam int PW = 4;
`ifdef CDB_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  localparam logic [NS-1:0] TAGS = 4'b1100;
  localparam logic [31:0] DATA [NS] = '{32'h0000_00A0, 32'h0000_00A1, 32'hDEAD_BEEF, 32'h0000_00A3};

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NS-1:0]   src_valid;
  logic [NS-1:0]   src_ready;
  logic [NS-1:0]   src_tag;
  logic [NS*32-1:0] src_data;
  logic            flush;
  logic            cdb_valid;
  logic [0:0]      cdb_tag;
  logic [31:0]     cdb_data;
  logic [1:0]      cdb_src;
  logic [NS*PW-1:0] perf_grant;
  logic [PW-1:0]   perf_conflict;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cdb_rr_arbiter #(.NUM_SRC(NS), .BW_TAG(1), .BW_DATA(32), .BW_PERF_CNT(PW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_src_valid         (src_valid),
    .i_src_ready         (src_ready),
    .i_src_tag           (src_tag),
    .i_src_data          (src_data),
    .i_flush             (flush),
    .o_cdb_valid         (cdb_valid),
    .o_cdb_tag           (cdb_tag),
    .o_cdb_data          (cdb_data),
    .o_cdb_src           (cdb_src),
    .o_perf_grant_cnt    (perf_grant),
    .o_perf_conflict_cnt (perf_conflict)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests, check ready combinationally, then advance past the edge.
  task automatic step(input string nm, input logic [NS-1:0] v, input logic fl, input logic [NS-1:0] exp_rdy);
    src_valid = v;
    flush     = fl;
    #1;
    check({nm, "_rdy"}, 64'(src_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic out_chk(input string nm, input logic ev, input int k);
    check({nm, "_valid"}, 64'(cdb_valid), 64'(ev));
    check({nm, "_src"},   64'(cdb_src),   64'(k));
    check({nm, "_tag"},   64'(cdb_tag),   64'(TAGS[k]));
    check({nm, "_data"},  64'(cdb_data),  64'(DATA[k]));
  endtask

  task automatic zero_chk(input string nm);
    check({nm, "_valid"}, 64'(cdb_valid), 64'd0);
    check({nm, "_src"},   64'(cdb_src),   64'd0);
    check({nm, "_tag"},   64'(cdb_tag),   64'd0);
    check({nm, "_data"},  64'(cdb_data),  64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    src_valid = '0;
    src_tag   = TAGS;
    src_data  = {DATA[3], DATA[2], DATA[1], DATA[0]};
    @(posedge clk);
    #1;

    step("reset", 4'b1111, 1'b0, 4'b0000);
    zero_chk("reset_out");
    check("reset_perf_grant", 64'(perf_grant), 64'd0);
    check("reset_perf_conf",  64'(perf_conflict), 64'd0);
    rst_n = 1'b1;

    step("single", 4'b0100, 1'b0, 4'b0100);
    out_chk("single_out", 1'b1, 2);
    step("idle", 4'b0000, 1'b0, 4'b0000);
    out_chk("idle_hold", 1'b0, 2);
    step("wrap3", 4'b1001, 1'b0, 4'b1000);
    out_chk("wrap3_out", 1'b1, 3);
    step("wrap0", 4'b1001, 1'b0, 4'b0001);
    out_chk("wrap0_out", 1'b1, 0);
    step("ptr1", 4'b1111, 1'b0, 4'b0010);
    out_chk("ptr1_out", 1'b1, 1);
    step("flush", 4'b0010, 1'b1, 4'b0000);
    out_chk("flush_out", 1'b0, 1);
    step("post_flush", 4'b0010, 1'b0, 4'b0010);
    out_chk("post_flush_out", 1'b1, 1);

    rst_n = 1'b0;
    step("rst2", 4'b1111, 1'b0, 4'b0000);
    zero_chk("rst2_out");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step($sformatf("rr%0d", i), 4'b1111, 1'b0, 4'(1 << (i % NS)));
      out_chk($sformatf("rr%0d_out", i), 1'b1, i % NS);
    end

    // src2 would be granted now; reset must discard it and rewind the pointer.
    rst_n = 1'b0;
    step("mid_rst", 4'b1111, 1'b0, 4'b0000);
    zero_chk("mid_rst_out");
    rst_n = 1'b1;
    step("after_rst", 4'b1111, 1'b0, 4'b0001);
    out_chk("after_rst_out", 1'b1, 0);

    rst_n = 1'b0;
    step("perf_rst", 4'b0000, 1'b0, 4'b0000);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step($sformatf("solo%0d", i), 4'b0001, 1'b0, 4'b0001);
      check($sformatf("solo%0d_src", i), 64'(cdb_src), 64'd0);
    end
    check("perf_grant0_sat", 64'(perf_grant[0 +: PW]), PERF_ON ? 64'd15 : 64'd0);
    check("perf_conf_solo",  64'(perf_conflict), 64'd0);
    step("conf", 4'b1111, 1'b0, 4'b0010);
    check("perf_conf_one",   64'(perf_conflict), PERF_ON ? 64'd1 : 64'd0);
    check("perf_grant1",     64'(perf_grant[PW +: PW]), PERF_ON ? 64'd1 : 64'd0);
    step("conf_flush", 4'b1111, 1'b1, 4'b0000);
    check("perf_conf_flush", 64'(perf_conflict), PERF_ON ? 64'd1 : 64'd0);
    check("flush_out_valid", 64'(cdb_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
